// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V main controller:
// state enum, opcodes, ALU operation codes and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        EXEC_NONE = 2'd0,
        EXEC_R    = 2'd1,
        EXEC_I    = 2'd2
    } exec_kind_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;

    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I       = 2'b00;
    localparam logic [1:0] IMM_S       = 2'b01;
    localparam logic [1:0] IMM_B       = 2'b10;
    localparam logic [1:0] IMM_J       = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_t;

    // Pure state-decoded controls; handshake-qualified strobes are formed in the top.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRC_A_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a  = SRC_A_OLDPC;
                c.alu_src_b  = SRC_B_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a  = SRC_A_RD1;
                c.alu_src_b  = SRC_B_IMM;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.mem_write  = 1'b1;
                c.adr_src    = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a  = SRC_A_RD1;
                c.alu_src_b  = SRC_B_RD2;
            end
            S_EXECUTEI: begin
                c.alu_src_a  = SRC_A_RD1;
                c.alu_src_b  = SRC_B_IMM;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRC_A_RD1;
                c.alu_src_b  = SRC_B_RD2;
                c.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                c.alu_src_a  = SRC_A_OLDPC;
                c.alu_src_b  = SRC_B_FOUR;
                c.result_src = RES_ALUOUT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode for the EXECUTE states of the multicycle controller.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  exec_kind_t  exec_kind,
    output logic [2:0]  alu_ctrl
);

    // funct7 only selects sub for genuine R-type; addi ignores it.
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (exec_kind == EXEC_NONE) begin
            alu_ctrl = ALU_ADD;
        end else begin
            case (funct3)
                3'b000: begin
                    if ((exec_kind == EXEC_R) && (op == OP_R) && (funct7 == 1'b1)) begin
                        alu_ctrl = ALU_SUB;
                    end else begin
                        alu_ctrl = ALU_ADD;
                    end
                end
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller FSM driving a shared-memory RISC-V datapath.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        is_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        halt
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t     state_r;
    state_t     next_state_s;
    ctrl_t      ctrl_r;
    logic [2:0] alu_ctrl_r;
    logic       halt_r;
    exec_kind_t exec_kind_s;
    logic [2:0] dec_alu_ctrl_s;
    logic [2:0] next_alu_ctrl_s;
    logic [1:0] imm_src_s;

    // Next-state sequencing, including handshake wait states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_START:    next_state_s = S_FETCH;
            S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECUTER;
                    OP_I:         next_state_s = S_EXECUTEI;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BEQ:      next_state_s = S_FETCH;
            S_JAL:      next_state_s = S_ALUWB;
            S_TRAP:     next_state_s = S_TRAP;
            default:    next_state_s = S_TRAP;
        endcase
    end

    // ALU op for the state being entered; IR fields are already stable before EXECUTE.
    always_comb begin
        exec_kind_s     = EXEC_NONE;
        next_alu_ctrl_s = ALU_ADD;
        case (next_state_s)
            S_EXECUTER: begin
                exec_kind_s     = EXEC_R;
                next_alu_ctrl_s = dec_alu_ctrl_s;
            end
            S_EXECUTEI: begin
                exec_kind_s     = EXEC_I;
                next_alu_ctrl_s = dec_alu_ctrl_s;
            end
            S_BEQ: begin
                exec_kind_s     = EXEC_NONE;
                next_alu_ctrl_s = ALU_SUB;
            end
            default: begin
                exec_kind_s     = EXEC_NONE;
                next_alu_ctrl_s = ALU_ADD;
            end
        endcase
    end

    mc_alu_dec u_alu_dec (
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .exec_kind (exec_kind_s),
        .alu_ctrl  (dec_alu_ctrl_s)
    );

    // State register with controls pre-decoded for the next state, so they leave a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_START;
            ctrl_r     <= '0;
            alu_ctrl_r <= ALU_ADD;
            halt_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            ctrl_r     <= state_ctrl(next_state_s);
            alu_ctrl_r <= next_alu_ctrl_s;
            halt_r     <= halt_r | (next_state_s == S_TRAP);
        end
    end

    // DECODE sees the freshly loaded IR, so its immediate format cannot be pre-registered.
    always_comb begin
        imm_src_s = IMM_I;
        case (state_r)
            S_DECODE:   imm_src_s = (op == OP_JAL) ? IMM_J : IMM_B;
            S_MEMADR:   imm_src_s = (op == OP_SW) ? IMM_S : IMM_I;
            S_EXECUTEI: imm_src_s = IMM_I;
            default:    imm_src_s = IMM_I;
        endcase
    end

    assign mem_req    = ctrl_r.mem_req;
    assign mem_write  = ctrl_r.mem_write;
    assign adr_src    = ctrl_r.adr_src;
    assign reg_write  = ctrl_r.reg_write;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign result_src = ctrl_r.result_src;
    assign alu_ctrl   = alu_ctrl_r;
    assign halt       = halt_r;
    assign imm_src    = imm_src_s;
    assign ir_write   = (state_r == S_FETCH) && mem_ready;
    assign pc_write   = ((state_r == S_FETCH) && mem_ready) ||
                        (state_r == S_JAL) ||
                        ((state_r == S_BEQ) && is_zero);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] instret_cnt_r;
    logic        active_s;
    logic        retire_s;

    // Retirement happens on the final cycle of each instruction; JAL retires at its ALUWB.
    always_comb begin
        active_s = (state_r != S_START) && (state_r != S_TRAP);
        retire_s = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BEQ) ||
                   ((state_r == S_MEMWRITE) && mem_ready);
    end

    // Free-running counters that wrap and freeze outside active execution.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_r   <= 32'd0;
            instret_cnt_r <= 32'd0;
        end else begin
            if (active_s) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (retire_s) begin
                instret_cnt_r <= instret_cnt_r + 32'd1;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are
// queued per instruction and compared at the falling edge.
`timescale 1ns/1ps
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        is_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [1:0]  result_src;
    logic        halt;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q[$];
    string       tag_q[$];
    logic [6:0]  pend_op;
    logic [2:0]  pend_f3;
    logic        pend_f7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .is_zero    (is_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .result_src (result_src),
        .halt       (halt)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // flags = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
    function automatic logic [21:0] vec(input state_t s, input logic [5:0] flags,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [1:0] imm,
                                        input logic [1:0] res, input logic h);
        return {s, flags, a, b, alu, imm, res, h};
    endfunction

    function automatic logic [21:0] observed();
        return {dut.state_r, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, halt};
    endfunction

    task automatic push(input string tag, input logic [21:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic load_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        pend_op = o;
        pend_f3 = f3;
        pend_f7 = f7;
    endtask

    // One clock: drive handshake, compare at negedge, model the IR load on the edge.
    task automatic step(input logic rdy, input logic zr);
        logic ld;
        mem_ready = rdy;
        is_zero   = zr;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_val(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
        end
        ld = ir_write;
        @(posedge clk);
        #1;
        if (ld) begin
            op     = pend_op;
            funct3 = pend_f3;
            funct7 = pend_f7;
        end
    endtask

    task automatic exp_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push("fetch_wait", vec(S_FETCH, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 1'b0));
        push("fetch", vec(S_FETCH, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 1'b0));
    endtask

    task automatic exp_decode(input logic [1:0] imm);
        push("decode", vec(S_DECODE, 6'b000000, 2'b01, 2'b01, 3'b000, imm, 2'b00, 1'b0));
    endtask

    task automatic exp_aluwb();
        push("aluwb", vec(S_ALUWB, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0));
    endtask

    task automatic do_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        load_ir(OP_R, f3, f7);
        exp_fetch(0);
        exp_decode(2'b10);
        push("exec_r", vec(S_EXECUTER, 6'b000000, 2'b10, 2'b00, alu, 2'b00, 2'b00, 1'b0));
        exp_aluwb();
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic exp_i(input logic [2:0] alu);
        exp_fetch(0);
        exp_decode(2'b10);
        push("exec_i", vec(S_EXECUTEI, 6'b000000, 2'b10, 2'b01, alu, 2'b00, 2'b00, 1'b0));
        exp_aluwb();
    endtask

    task automatic do_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        load_ir(OP_I, f3, f7);
        exp_i(alu);
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic do_lw(input int fw, input int rw);
        load_ir(OP_LW, 3'b010, 1'b0);
        exp_fetch(fw);
        exp_decode(2'b10);
        push("memadr_lw", vec(S_MEMADR, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i <= rw; i++)
            push("memread", vec(S_MEMREAD, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0));
        push("memwb", vec(S_MEMWB, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 1'b0));
        repeat (fw) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (rw) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
    endtask

    task automatic exp_sw_front();
        load_ir(OP_SW, 3'b010, 1'b0);
        exp_fetch(0);
        exp_decode(2'b10);
        push("memadr_sw", vec(S_MEMADR, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00, 1'b0));
    endtask

    task automatic do_beq(input logic zr);
        load_ir(OP_BEQ, 3'b000, 1'b0);
        exp_fetch(0);
        exp_decode(2'b10);
        push(zr ? "beq_taken" : "beq_not_taken",
             vec(S_BEQ, zr ? 6'b000010 : 6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0));
        repeat (3) step(1'b1, zr);
    endtask

    task automatic do_jal();
        load_ir(OP_JAL, 3'b000, 1'b0);
        exp_fetch(0);
        exp_decode(2'b11);
        push("jal", vec(S_JAL, 6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 1'b0));
        exp_aluwb();
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push("start", vec(S_START, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0));
        step(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
        is_zero = 1'b0; mem_ready = 1'b0;
        load_ir(7'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", 32'(observed()),
                  32'(vec(S_START, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0)));
        release_reset();

        do_r(3'b000, 1'b0, 3'b000);     // add
        do_lw(2, 1);                    // 8 cycles with wait states
        exp_sw_front();
        push("memwrite", vec(S_MEMWRITE, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0));
        repeat (4) step(1'b1, 1'b0);
        do_r(3'b000, 1'b1, 3'b001);     // sub
        do_r(3'b110, 1'b0, 3'b011);     // or
        do_r(3'b111, 1'b0, 3'b010);     // and
        do_r(3'b010, 1'b0, 3'b101);     // slt
        do_r(3'b100, 1'b0, 3'b000);     // unsupported funct3
        do_i(3'b000, 1'b1, 3'b000);     // addi ignores funct7
        do_i(3'b110, 1'b0, 3'b011);     // ori
        do_i(3'b010, 1'b0, 3'b101);     // slti
        do_beq(1'b1);
        do_beq(1'b0);
        do_jal();
        do_lw(0, 0);

        // Illegal opcode traps and holds halt
        load_ir(7'b0000000, 3'b000, 1'b0);
        exp_fetch(0);
        exp_decode(2'b10);
        for (int i = 0; i < 3; i++)
            push("trap", vec(S_TRAP, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b1));
        repeat (5) step(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 check_val("trap_reset", 32'(observed()),
                     32'(vec(S_START, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0)));
        release_reset();

        // Reset in the middle of a stalled store
        exp_sw_front();
        for (int i = 0; i < 2; i++)
            push("memwrite_wait", vec(S_MEMWRITE, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0));
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check_val("memwrite_req_held", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1 check_val("rst_mid_write", 32'(observed()),
                     32'(vec(S_START, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0)));
        check_val("rst_mid_write_req", 32'(mem_req), 32'd0);
        release_reset();

`ifdef MC_CTRL_PERF_EN
        for (int n = 0; n < 10; n++) do_i(3'b000, 1'b0, 3'b000);
        check_val("cycle_cnt_10addi", cycle_cnt, 32'd40);
        check_val("instret_10addi", instret_cnt, 32'd10);
        force dut.cycle_cnt_r = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt_r;
        load_ir(OP_I, 3'b000, 1'b0);
        exp_i(3'b000);
        step(1'b1, 1'b0);
        check_val("cycle_cnt_wrap", cycle_cnt, 32'd0);
        repeat (3) step(1'b1, 1'b0);
        check_val("instret_after_wrap", instret_cnt, 32'd11);
`endif

        check_val("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
